reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Parametrised successor to the single-stage reset synchroniser. Takes NUM_SRC asynchronous active-low
//  reset requests and one synchronous software request. Synchronises and glitch-filters each request,
//  stretches the combined reset, then releases NUM_STAGES ordered local resets with a fixed gap between stages
//  (e.g. clocks/PLL logic, then register bank, then OPL3 pipeline). Records the reset cause.
// PARAMETERS
//  NUM_SRC        2   number of async active-low request inputs (>=1)
//  SYNC_STAGES    3   synchroniser flops per request input (>=2)
//  FILTER_CYCLES  4   consecutive synced-low cycles needed to accept a request (>=1)
//  HOLD_CYCLES    16  request-free cycles before the first stage releases (>=1)
//  NUM_STAGES     3   number of sequenced reset outputs (>=1)
//  STAGE_GAP      8   cycles between successive stage releases (>=1)
//  Any illegal value -> elaboration error ($error in generate).
// PORTS
//  clk           in   1              clock for all logic
//  reset         in   1              synchronous, active-high block reset
//  arst_n_in     in   NUM_SRC        async active-low reset requests; one bit per source
//  sw_reset      in   1              sync single-cycle software reset request
//  cause_clr     in   1              sync pulse; clears cause
//  rst_out       out  NUM_STAGES     active-high local resets; bit 0 releases first
//  all_released  out  1              1 when every rst_out bit is 0 (state RUN)
//  cause         out  NUM_SRC+1      sticky cause bits: [k]=arst_n_in[k], [NUM_SRC]=sw_reset
// BEHAVIOUR
//  Reset values: rst_out = all 1s, all_released = 0, cause = 0, state = HOLD, counters = 0, sync flops = 1.
//  Sync: per-source chain of SYNC_STAGES flops, marked ASYNC_REG.
//  Filter: filt[k] sets after FILTER_CYCLES consecutive cycles with synced input low. It clears on the first
//  synced-high cycle. Release is not filtered.
//  req = |filt | sw_reset.
//  FSM states:
//   HOLD: all rst_out = 1. hold_cnt increments each cycle req=0 and clears to 0 when req=1.
//    After HOLD_CYCLES consecutive req=0 cycles -> RELEASE; rst_out[0] = 0 on that edge; gap_cnt = 0.
//   RELEASE: gap_cnt counts. Every STAGE_GAP cycles the next rst_out bit falls, in ascending index.
//    When rst_out[NUM_STAGES-1] falls -> RUN; all_released = 1 on that same edge.
//    If NUM_STAGES = 1, go HOLD -> RUN directly.
//   RUN: rst_out = 0, all_released = 1.
//   In RELEASE or RUN, req = 1 -> on the next edge all rst_out = 1, all_released = 0, hold_cnt = 0, state HOLD.
//  Released stages never re-release out of order. rst_out bits are monotonic: bit i = 0 implies bit i-1 = 0.
//  Latency:
//   sw_reset -> rst_out all 1s: 1 edge.
//   arst_n_in[k] fall -> rst_out all 1s: at most SYNC_STAGES + FILTER_CYCLES + 1 edges.
//  Counters: width $clog2(max(HOLD_CYCLES, STAGE_GAP) + 1). They saturate and never wrap.
//  Release timing: after reset falls with no requests, counting the first edge with reset=0 as edge 1,
//  rst_out[i] falls at edge HOLD_CYCLES + i*STAGE_GAP.
//  cause:
//   bit k set on the rising edge of filt[k]; bit NUM_SRC set on sw_reset.
//   Setting wins over a simultaneous cause_clr. Simultaneous sources set all of their bits.
//  reset mid-operation: all state returns to the reset values on the next edge, including cause.
//  Reset has priority over every other input.
// TESTING (defaults)
//  1. reset high 5 cycles then low, sources high -> rst_out=111 until edge 16;
//     then 110 @16, 100 @24, 000 @32; all_released=1 @32.
//  2. In RUN, arst_n_in[0] low 3 cycles -> no change, cause=000.
//     Low 6 cycles -> rst_out=111 within 8 edges of the fall, cause=001;
//     rst_out[0] falls 16 edges after filt[0] clears.
//  3. sw_reset pulse in RELEASE with rst_out=110 -> next edge rst_out=111, all_released=0, cause[2]=1,
//     full HOLD restarts.
//  4. sw_reset in HOLD at hold_cnt=10 -> hold_cnt=0; rst_out[0] falls exactly 16 edges after the pulse edge.
//  5. cause_clr in the same cycle as sw_reset -> cause[2]=1.
//     Both arst_n_in low together for 10 cycles -> cause=011.
//     cause_clr alone -> 000.
//  6. reset asserted mid-RELEASE (rst_out=100) -> next edge rst_out=111, cause=000, state HOLD;
//     test 1 timing repeats after reset falls.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Collects NUM_SRC asynchronous active-low reset requests and one synchronous software request.
//   Each async request is synchronised and glitch-filtered. The combined request holds every local
//   reset asserted. Once HOLD_CYCLES request-free cycles have passed, the local resets release one
//   at a time, STAGE_GAP cycles apart and in ascending bit order. A sticky cause register records
//   which requests fired.
// Ports
//   clk          : clock for all logic
//   reset        : synchronous active-high block reset; overrides every other input
//   arst_n_in    : [NUM_SRC] asynchronous active-low reset requests
//   sw_reset     : synchronous single-cycle software reset request
//   cause_clr    : synchronous pulse that clears cause (a simultaneous set wins)
//   rst_out      : [NUM_STAGES] active-high local resets; bit 0 releases first
//   all_released : high while every rst_out bit is low
//   cause        : [NUM_SRC+1] sticky cause bits; [k] = arst_n_in[k], [NUM_SRC] = sw_reset
module reset_sequencer #(
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned NUM_STAGES    = 3,
  parameter int unsigned STAGE_GAP     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC-1:0]    arst_n_in,
  input  logic                  sw_reset,
  input  logic                  cause_clr,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  all_released,
  output logic [NUM_SRC:0]      cause
);

  if (NUM_SRC == 0)       begin : gen_bad_num_src   $error("NUM_SRC must be >= 1");       end
  if (SYNC_STAGES < 2)    begin : gen_bad_sync      $error("SYNC_STAGES must be >= 2");   end
  if (FILTER_CYCLES == 0) begin : gen_bad_filter    $error("FILTER_CYCLES must be >= 1"); end
  if (HOLD_CYCLES == 0)   begin : gen_bad_hold      $error("HOLD_CYCLES must be >= 1");   end
  if (NUM_STAGES == 0)    begin : gen_bad_stages    $error("NUM_STAGES must be >= 1");    end
  if (STAGE_GAP == 0)     begin : gen_bad_gap       $error("STAGE_GAP must be >= 1");     end

  localparam int unsigned CntMax = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned FltW   = $clog2(FILTER_CYCLES + 1);

  localparam logic [CntW-1:0]       HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]       GapLast  = CntW'(STAGE_GAP - 1);
  localparam logic [FltW-1:0]       FltMax   = FltW'(FILTER_CYCLES);
  // Reset vector after the first stage has dropped.
  localparam logic [NUM_STAGES-1:0] FirstRel = {NUM_STAGES{1'b1}} << 1;

  typedef enum logic [1:0] {StHold, StRelease, StRun} state_e;

  (* ASYNC_REG = "TRUE" *) logic [NUM_SRC-1:0][SYNC_STAGES-1:0] sync_q;

  logic [NUM_SRC-1:0][FltW-1:0] flt_cnt_q, flt_cnt_d;
  logic [NUM_SRC-1:0]           filt_q, filt_d;
  logic                         req;
  state_e                       state_q, state_d;
  logic [CntW-1:0]              hold_cnt_q, hold_cnt_d;
  logic [CntW-1:0]              gap_cnt_q, gap_cnt_d;
  logic [NUM_STAGES-1:0]        rst_out_q, rst_out_d;
  logic [NUM_SRC:0]             cause_q, cause_d;

  // Glitch filter: assert only after FILTER_CYCLES consecutive synced-low samples; any high
  // sample drops the request immediately.
  always_comb begin
    flt_cnt_d = flt_cnt_q;
    filt_d    = filt_q;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (sync_q[k][SYNC_STAGES-1]) begin
        flt_cnt_d[k] = '0;
        filt_d[k]    = 1'b0;
      end else begin
        flt_cnt_d[k] = (flt_cnt_q[k] == FltMax) ? flt_cnt_q[k] : flt_cnt_q[k] + FltW'(1);
        filt_d[k]    = (flt_cnt_d[k] == FltMax);
      end
    end
  end

  assign req = (|filt_q) | sw_reset;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rst_out_d  = rst_out_q;
    case (state_q)
      StHold: begin
        rst_out_d = '1;
        if (req) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q >= HoldLast) begin
          hold_cnt_d = '0;
          gap_cnt_d  = '0;
          rst_out_d  = FirstRel;
          state_d    = (NUM_STAGES == 1) ? StRun : StRelease;
        end else begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        if (req) begin
          rst_out_d  = '1;
          hold_cnt_d = '0;
          state_d    = StHold;
        end else if (gap_cnt_q >= GapLast) begin
          gap_cnt_d = '0;
          // Shifting in a zero keeps the vector monotonic: bit i only falls after bit i-1.
          rst_out_d = rst_out_q << 1;
          if (rst_out_d == '0) state_d = StRun;
        end else begin
          gap_cnt_d = gap_cnt_q + CntW'(1);
        end
      end
      StRun: begin
        rst_out_d = '0;
        if (req) begin
          rst_out_d  = '1;
          hold_cnt_d = '0;
          state_d    = StHold;
        end
      end
      default: begin
        rst_out_d  = '1;
        hold_cnt_d = '0;
        state_d    = StHold;
      end
    endcase
  end

  // Sets are OR-ed in after the clear so a same-cycle event is never lost.
  always_comb begin
    cause_d                = cause_clr ? '0 : cause_q;
    cause_d[NUM_SRC-1:0]   = cause_d[NUM_SRC-1:0] | (filt_d & ~filt_q);
    cause_d[NUM_SRC]       = cause_d[NUM_SRC] | sw_reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '1;
      flt_cnt_q  <= '0;
      filt_q     <= '0;
      state_q    <= StHold;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      rst_out_q  <= '1;
      cause_q    <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], arst_n_in[k]};
      end
      flt_cnt_q  <= flt_cnt_d;
      filt_q     <= filt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rst_out_q  <= rst_out_d;
      cause_q    <= cause_d;
    end
  end

  assign rst_out      = rst_out_q;
  assign all_released = (state_q == StRun);
  assign cause        = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters. Expected output snapshots are queued
// when stimulus is applied and popped for comparison once the DUT has had the edges to respond.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] arst_n_in;
  logic       sw_reset;
  logic       cause_clr;
  logic [2:0] rst_out;
  logic       all_released;
  logic [2:0] cause;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_SRC      (2),
    .SYNC_STAGES  (3),
    .FILTER_CYCLES(4),
    .HOLD_CYCLES  (16),
    .NUM_STAGES   (3),
    .STAGE_GAP    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arst_n_in   (arst_n_in),
    .sw_reset    (sw_reset),
    .cause_clr   (cause_clr),
    .rst_out     (rst_out),
    .all_released(all_released),
    .cause       (cause)
  );

  typedef struct {
    string      tag;
    logic [2:0] rst;
    logic       rel;
    logic [2:0] cs;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input string tag, input logic [2:0] r, input logic a,
                          input logic [2:0] c);
    exp_t e;
    e.tag = tag;
    e.rst = r;
    e.rel = a;
    e.cs  = c;
    sb_q.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: got no queued entry, required one");
    end else begin
      e = sb_q.pop_front();
      assert ({rst_out, all_released, cause} === {e.rst, e.rel, e.cs}) else begin
        n_fail++;
        $error("FAIL %s: got rst_out=%b all_released=%b cause=%b, required rst_out=%b all_released=%b cause=%b",
               e.tag, rst_out, all_released, cause, e.rst, e.rel, e.cs);
      end
    end
  endtask

  task automatic expect_after(input int n, input string tag, input logic [2:0] r,
                              input logic a, input logic [2:0] c);
    push_exp(tag, r, a, c);
    step(n);
    check_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time 200000, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hit;
    reset     = 1'b1;
    arst_n_in = 2'b11;
    sw_reset  = 1'b0;
    cause_clr = 1'b0;

    expect_after(5, "reset_state", 3'b111, 1'b0, 3'b000);
    reset = 1'b0;

    // Release timing from reset: edges 16, 24, 32.
    expect_after(15, "t1_e15", 3'b111, 1'b0, 3'b000);
    expect_after(1,  "t1_e16", 3'b110, 1'b0, 3'b000);
    expect_after(7,  "t1_e23", 3'b110, 1'b0, 3'b000);
    expect_after(1,  "t1_e24", 3'b100, 1'b0, 3'b000);
    expect_after(7,  "t1_e31", 3'b100, 1'b0, 3'b000);
    expect_after(1,  "t1_e32", 3'b000, 1'b1, 3'b000);

    // Short glitch is filtered out.
    arst_n_in[0] = 1'b0;
    step(3);
    arst_n_in[0] = 1'b1;
    expect_after(10, "t2_glitch", 3'b000, 1'b1, 3'b000);

    // Six-cycle low is accepted within SYNC_STAGES + FILTER_CYCLES + 1 edges.
    arst_n_in[0] = 1'b0;
    hit = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (i == 6) arst_n_in[0] = 1'b1;
      if (hit == 0 && rst_out === 3'b111) hit = i;
    end
    n_tests++;
    assert (hit != 0) else begin
      n_fail++;
      $error("FAIL t2_latency: got rst_out=%b after 8 edges, required 111 within 8 edges", rst_out);
    end
    expect_after(0,  "t2_cause",  3'b111, 1'b0, 3'b001);
    // Filter clears at edge 10 after the fall, so stage 0 drops at edge 26.
    expect_after(17, "t2_e25",    3'b111, 1'b0, 3'b001);
    expect_after(1,  "t2_e26",    3'b110, 1'b0, 3'b001);

    // Software reset during RELEASE restarts the full hold.
    sw_reset = 1'b1;
    expect_after(1, "t3_pulse", 3'b111, 1'b0, 3'b101);
    sw_reset = 1'b0;
    expect_after(15, "t3_p15", 3'b111, 1'b0, 3'b101);
    expect_after(1,  "t3_p16", 3'b110, 1'b0, 3'b101);

    // Software reset with hold_cnt at 10 restarts the count.
    sw_reset = 1'b1;
    expect_after(1, "t4_enter_hold", 3'b111, 1'b0, 3'b101);
    sw_reset = 1'b0;
    step(10);
    sw_reset = 1'b1;
    expect_after(1, "t4_pulse", 3'b111, 1'b0, 3'b101);
    sw_reset = 1'b0;
    expect_after(15, "t4_p15", 3'b111, 1'b0, 3'b101);
    expect_after(1,  "t4_p16", 3'b110, 1'b0, 3'b101);
    expect_after(16, "t4_run", 3'b000, 1'b1, 3'b101);

    // Cause register behaviour.
    cause_clr = 1'b1;
    expect_after(1, "t5_clr", 3'b000, 1'b1, 3'b000);
    sw_reset  = 1'b1;
    expect_after(1, "t5_set_wins", 3'b111, 1'b0, 3'b100);
    sw_reset  = 1'b0;
    expect_after(1, "t5_clr2", 3'b111, 1'b0, 3'b000);
    cause_clr = 1'b0;
    arst_n_in = 2'b00;
    expect_after(10, "t5_both", 3'b111, 1'b0, 3'b011);
    arst_n_in = 2'b11;
    cause_clr = 1'b1;
    expect_after(1, "t5_clr3", 3'b111, 1'b0, 3'b000);
    cause_clr = 1'b0;

    // Block reset mid-RELEASE wipes everything, then the reset timing repeats.
    step(5);
    sw_reset = 1'b1;
    expect_after(1, "t6_sw", 3'b111, 1'b0, 3'b100);
    sw_reset = 1'b0;
    expect_after(23, "t6_s23", 3'b110, 1'b0, 3'b100);
    expect_after(1,  "t6_s24", 3'b100, 1'b0, 3'b100);
    reset = 1'b1;
    expect_after(1, "t6_reset", 3'b111, 1'b0, 3'b000);
    reset = 1'b0;
    expect_after(15, "t6_e15", 3'b111, 1'b0, 3'b000);
    expect_after(1,  "t6_e16", 3'b110, 1'b0, 3'b000);
    expect_after(7,  "t6_e23", 3'b110, 1'b0, 3'b000);
    expect_after(1,  "t6_e24", 3'b100, 1'b0, 3'b000);
    expect_after(7,  "t6_e31", 3'b100, 1'b0, 3'b000);
    expect_after(1,  "t6_e32", 3'b000, 1'b1, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
